// File: rtl/cache_miss_fsm_if.sv
// Request and datapath bundle between the cache controller side
// and the miss sequencer.
interface cache_miss_fsm_if #(
  parameter int TAG_SIZE    = 8,
  parameter int INDEX_SIZE  = 3,
  parameter int OFFSET_SIZE = 5
) ();
  localparam int SW = INDEX_SIZE + OFFSET_SIZE;
  localparam int AW = TAG_SIZE + SW;

  logic                   req;
  logic                   hit;
  logic                   dirty;
  logic                   wr_rd_cpu_q;
  logic [TAG_SIZE-1:0]    tag_new;
  logic [TAG_SIZE-1:0]    tag_old;
  logic [INDEX_SIZE-1:0]  index;
  logic [OFFSET_SIZE-1:0] offset;

  logic                   busy;
  logic                   done;
  logic [AW-1:0]          Address_sdram;
  logic                   wr_rd_sdram;
  logic                   mstrb_sdram;
  logic                   mux_sel;
  logic                   demux_sel;
  logic                   wen_sram;
  logic [SW-1:0]          address_sram;
  logic                   tag_update;
  logic                   set_dirty;

  modport master (
    output req, hit, dirty, wr_rd_cpu_q,
    output tag_new, tag_old, index, offset,
    input  busy, done, Address_sdram,
    input  wr_rd_sdram, mstrb_sdram,
    input  mux_sel, demux_sel, wen_sram,
    input  address_sram, tag_update, set_dirty
  );

  modport slave (
    input  req, hit, dirty, wr_rd_cpu_q,
    input  tag_new, tag_old, index, offset,
    output busy, done, Address_sdram,
    output wr_rd_sdram, mstrb_sdram,
    output mux_sel, demux_sel, wen_sram,
    output address_sram, tag_update, set_dirty
  );
endinterface

// File: rtl/cache_miss_fsm.sv
// Hit / write-back / line-fill sequencer driving the SRAM
// datapath selects and the strobed SDRAM interface.
module cache_miss_fsm #(
  parameter int TAG_SIZE    = 8,
  parameter int INDEX_SIZE  = 3,
  parameter int OFFSET_SIZE = 5,
  parameter int SDRAM_WAIT  = 3
) (
  input logic            clk,
  input logic            rst,
  cache_miss_fsm_if.slave bus
);
  localparam int SW = INDEX_SIZE + OFFSET_SIZE;
  localparam int AW = TAG_SIZE + SW;
  localparam logic [3:0] WAIT_LAST = 4'(SDRAM_WAIT - 1);
  localparam logic [OFFSET_SIZE-1:0] K_LAST = {OFFSET_SIZE{1'b1}};

  typedef enum logic [3:0] {
    IDLE,
    WB_RD,
    WB_STB,
    WB_WAIT,
    FILL_STB,
    FILL_WAIT,
    FILL_WR,
    TAG_UPD,
    ACCESS,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [OFFSET_SIZE-1:0] k, k_nx;
  logic [3:0]             wcnt, wcnt_nx;
  logic                   wait_last;

  logic                   wr_q;
  logic [TAG_SIZE-1:0]    tag_new_q;
  logic [TAG_SIZE-1:0]    tag_old_q;
  logic [INDEX_SIZE-1:0]  index_q;
  logic [OFFSET_SIZE-1:0] offset_q;

  logic [SW-1:0] sram_hold;
  logic [AW-1:0] sdram_hold;

  assign wait_last = (wcnt == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      wcnt       <= '0;
      wr_q       <= 1'b0;
      tag_new_q  <= '0;
      tag_old_q  <= '0;
      index_q    <= '0;
      offset_q   <= '0;
      sram_hold  <= '0;
      sdram_hold <= '0;
    end else begin
      state      <= state_nx;
      k          <= k_nx;
      wcnt       <= wcnt_nx;
      sram_hold  <= bus.address_sram;
      sdram_hold <= bus.Address_sdram;
      if (state == IDLE && bus.req) begin
        wr_q      <= bus.wr_rd_cpu_q;
        tag_new_q <= bus.tag_new;
        tag_old_q <= bus.tag_old;
        index_q   <= bus.index;
        offset_q  <= bus.offset;
      end
    end
  end

  always_comb begin
    state_nx          = state;
    k_nx              = k;
    wcnt_nx           = wcnt;
    bus.busy          = 1'b0;
    bus.done          = 1'b0;
    bus.Address_sdram = sdram_hold;
    bus.wr_rd_sdram   = 1'b0;
    bus.mstrb_sdram   = 1'b0;
    bus.mux_sel       = 1'b0;
    bus.demux_sel     = 1'b0;
    bus.wen_sram      = 1'b0;
    bus.address_sram  = sram_hold;
    bus.tag_update    = 1'b0;
    bus.set_dirty     = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.req) begin
          k_nx    = '0;
          wcnt_nx = '0;
          if (bus.hit)
            state_nx = ACCESS;
          else if (bus.dirty)
            state_nx = WB_RD;
          else
            state_nx = FILL_STB;
        end
      end

      WB_RD: begin
        bus.busy         = 1'b1;
        bus.address_sram = {index_q, k};
        bus.demux_sel    = 1'b1;
        state_nx         = WB_STB;
      end

      WB_STB: begin
        bus.busy          = 1'b1;
        bus.Address_sdram = {tag_old_q, index_q, k};
        bus.wr_rd_sdram   = 1'b1;
        bus.mstrb_sdram   = 1'b1;
        bus.demux_sel     = 1'b1;
        state_nx          = WB_WAIT;
      end

      WB_WAIT: begin
        bus.busy = 1'b1;
        if (wait_last) begin
          wcnt_nx = '0;
          // k wraps to zero on the last byte, ready for the fill
          k_nx     = k + 1'b1;
          state_nx = (k == K_LAST) ? FILL_STB : WB_RD;
        end else begin
          wcnt_nx = wcnt + 4'd1;
        end
      end

      FILL_STB: begin
        bus.busy          = 1'b1;
        bus.Address_sdram = {tag_new_q, index_q, k};
        bus.mstrb_sdram   = 1'b1;
        state_nx          = FILL_WAIT;
      end

      FILL_WAIT: begin
        bus.busy = 1'b1;
        if (wait_last) begin
          wcnt_nx  = '0;
          state_nx = FILL_WR;
        end else begin
          wcnt_nx = wcnt + 4'd1;
        end
      end

      FILL_WR: begin
        bus.busy         = 1'b1;
        bus.address_sram = {index_q, k};
        bus.mux_sel      = 1'b1;
        bus.wen_sram     = 1'b1;
        k_nx             = k + 1'b1;
        state_nx         = (k == K_LAST) ? TAG_UPD : FILL_STB;
      end

      TAG_UPD: begin
        bus.busy       = 1'b1;
        bus.tag_update = 1'b1;
        state_nx       = ACCESS;
      end

      ACCESS: begin
        bus.busy         = 1'b1;
        bus.address_sram = {index_q, offset_q};
        if (wr_q) begin
          bus.wen_sram  = 1'b1;
          bus.set_dirty = 1'b1;
        end
        state_nx = DONE;
      end

      DONE: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end
endmodule
